// File: rtl/bnn_fc_argmax.sv
// Binary FC layer (XNOR-popcount over ten classes) followed by a sequential argmax.
// Optional score_max output enabled by defining BNN_FC_SCORE_OUT_EN.
module bnn_fc_argmax #(
    parameter int N_IN  = 800,
    parameter int ACC_W = 10
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             act_in,
    input  logic             act_valid,
    input  logic [9:0]       weight_fc_in,
    output logic             fc_ivalid,
    output logic             done,
    output logic [3:0]       classes_b
`ifdef BNN_FC_SCORE_OUT_EN
    ,
    output logic [ACC_W-1:0] score_max
`endif
);

    localparam int CNT_W = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_IN - 1);

    typedef enum logic [2:0] {IDLE, ACCUM, DRAIN, ARGMAX, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] in_cnt;
    logic             act_q;
    logic             wt_pend;
    logic [ACC_W-1:0] score [10];
    logic [3:0]       idx;
    logic [3:0]       best_idx;
    logic [ACC_W-1:0] best;

    logic             take;
    logic [ACC_W-1:0] nxt_best;
    logic [3:0]       nxt_idx;

    always_comb begin
        fc_ivalid = (state == ACCUM) && act_valid;
    end

    // idx 0 always seeds the running max; later entries need a strict win
    always_comb begin
        take     = (idx == 4'd0) || (score[idx] > best);
        nxt_best = take ? score[idx] : best;
        nxt_idx  = take ? idx : best_idx;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            in_cnt    <= '0;
            act_q     <= 1'b0;
            wt_pend   <= 1'b0;
            idx       <= '0;
            best_idx  <= '0;
            best      <= '0;
            done      <= 1'b0;
            classes_b <= '0;
`ifdef BNN_FC_SCORE_OUT_EN
            score_max <= '0;
`endif
            for (int unsigned k = 0; k < 10; k++) begin
                score[k] <= '0;
            end
        end else begin
            done <= 1'b0;
            // weights arrive one cycle after the request, aligned with act_q
            if (wt_pend) begin
                for (int unsigned k = 0; k < 10; k++) begin
                    score[k] <= score[k] + {{(ACC_W-1){1'b0}}, act_q ~^ weight_fc_in[k]};
                end
            end
            case (state)
                IDLE: begin
                    wt_pend <= 1'b0;
                    if (start) begin
                        for (int unsigned k = 0; k < 10; k++) begin
                            score[k] <= '0;
                        end
                        in_cnt <= '0;
                        state  <= ACCUM;
                    end
                end
                ACCUM: begin
                    wt_pend <= act_valid;
                    if (act_valid) begin
                        act_q  <= act_in;
                        in_cnt <= in_cnt + 1'b1;
                        if (in_cnt == LAST) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    wt_pend <= 1'b0;
                    idx     <= '0;
                    state   <= ARGMAX;
                end
                ARGMAX: begin
                    best     <= nxt_best;
                    best_idx <= nxt_idx;
                    idx      <= idx + 1'b1;
                    if (idx == 4'd9) begin
                        classes_b <= nxt_idx;
                        done      <= 1'b1;
`ifdef BNN_FC_SCORE_OUT_EN
                        score_max <= nxt_best;
`endif
                        state     <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
